// File: rtl/serial_add_scheduler_pkg.sv
// rtl/serial_add_scheduler_pkg.sv - shared state encoding and size defaults
package serial_add_scheduler_pkg;

  localparam int DEF_WIDTH   = 8;
  localparam int DEF_LATENCY = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_LOAD  = 3'd2,
    ST_RUN   = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/serial_add_scheduler_if.sv
// rtl/serial_add_scheduler_if.sv - bus between the scheduler and the shared serial adder
interface serial_add_scheduler_if
  import serial_add_scheduler_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) ();

  logic             add_reset;
  logic             add_load;
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic [WIDTH-1:0] add_result;
  logic             add_carry;

  modport master (
    output add_reset, add_load, add_a, add_b,
    input  add_result, add_carry
  );

  modport slave (
    input  add_reset, add_load, add_a, add_b,
    output add_result, add_carry
  );

endinterface

// File: rtl/serial_add_scheduler_rr_arb2.sv
// rtl/serial_add_scheduler_rr_arb2.sv - two-way round-robin arbiter, combinational
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/serial_add_scheduler.sv
// rtl/serial_add_scheduler.sv - time-shares one serial adder between two requesters
module serial_add_scheduler
  import serial_add_scheduler_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int LATENCY = DEF_LATENCY
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [1:0]              req_i,
  input  logic [WIDTH-1:0]        a0_i,
  input  logic [WIDTH-1:0]        b0_i,
  input  logic [WIDTH-1:0]        a1_i,
  input  logic [WIDTH-1:0]        b1_i,
  output logic [1:0]              grant_o,
  output logic [1:0]              done_o,
  output logic [WIDTH:0]          sum_o,
  output logic                    busy_o,
  serial_add_scheduler_if.master  add_bus
);

  localparam int CW = $clog2(LATENCY + 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             last_q, last_d;
  logic             win_q, win_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH:0]   sum_q, sum_d;
  logic [1:0]       arb_gnt;

  rr_arb2 u_arb (
    .req   (req_i),
    .last  (last_q),
    .grant (arb_gnt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      win_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      win_q   <= win_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    win_d   = win_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    case (state_q)
      ST_IDLE: begin
        if (|req_i) begin
          win_d   = arb_gnt[1];
          a_d     = arb_gnt[0] ? a0_i : a1_i;
          b_d     = arb_gnt[0] ? b0_i : b1_i;
          state_d = ST_CLEAR;
        end
      end
      ST_CLEAR: state_d = ST_LOAD;
      ST_LOAD: begin
        cnt_d   = CW'(1);
        state_d = ST_RUN;
      end
      ST_RUN: begin
        // Result is sampled in the LATENCY-th cycle after the load cycle.
        if (cnt_q == CW'(LATENCY)) begin
          sum_d   = {add_bus.add_carry, add_bus.add_result};
          cnt_d   = '0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DONE: begin
        last_d  = win_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    grant_o          = (state_q != ST_IDLE) ? onehot2(win_q) : 2'b00;
    done_o           = (state_q == ST_DONE) ? onehot2(win_q) : 2'b00;
    busy_o           = (state_q != ST_IDLE);
    sum_o            = sum_q;
    add_bus.add_reset = reset || (state_q == ST_CLEAR);
    add_bus.add_load  = (state_q == ST_LOAD);
    add_bus.add_a     = (state_q == ST_LOAD || state_q == ST_RUN) ? a_q : '0;
    add_bus.add_b     = (state_q == ST_LOAD || state_q == ST_RUN) ? b_q : '0;
  end

endmodule

// File: tb/tb_serial_add_scheduler.sv
// tb/tb_serial_add_scheduler.sv - self-checking bench with a bit-serial adder beside the scheduler
module tb_serial_add_scheduler;
  import serial_add_scheduler_pkg::*;

  localparam int W = DEF_WIDTH;
  localparam int L = DEF_LATENCY;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   req_i;
  logic [W-1:0] a0_i, b0_i, a1_i, b1_i;
  logic [1:0]   grant_o, done_o;
  logic [W:0]   sum_o;
  logic         busy_o;

  int n_vec = 0;
  int n_err = 0;
  logic ptr;

  serial_add_scheduler_if #(.WIDTH(W)) bus ();

  serial_add_scheduler #(.WIDTH(W), .LATENCY(L)) dut (
    .clk     (clk),
    .reset   (reset),
    .req_i   (req_i),
    .a0_i    (a0_i),
    .b0_i    (b0_i),
    .a1_i    (a1_i),
    .b1_i    (b1_i),
    .grant_o (grant_o),
    .done_o  (done_o),
    .sum_o   (sum_o),
    .busy_o  (busy_o),
    .add_bus (bus)
  );

  always #5 clk = ~clk;

  // Bit-serial adder: bit 0 is produced on the load edge, one more bit per edge after.
  logic [W-1:0] ad_a, ad_b, ad_res;
  logic         ad_c;
  int           ad_cnt;

  always @(posedge clk) begin
    if (bus.add_reset) begin
      ad_a <= '0; ad_b <= '0; ad_res <= '0; ad_c <= 1'b0; ad_cnt <= W;
    end else if (bus.add_load) begin
      ad_res <= {bus.add_a[0] ^ bus.add_b[0], ad_res[W-1:1]};
      ad_c   <= bus.add_a[0] & bus.add_b[0];
      ad_a   <= bus.add_a >> 1;
      ad_b   <= bus.add_b >> 1;
      ad_cnt <= 1;
    end else if (ad_cnt < W) begin
      ad_res <= {ad_a[0] ^ ad_b[0] ^ ad_c, ad_res[W-1:1]};
      ad_c   <= (ad_a[0] & ad_b[0]) | (ad_c & (ad_a[0] ^ ad_b[0]));
      ad_a   <= ad_a >> 1;
      ad_b   <= ad_b >> 1;
      ad_cnt <= ad_cnt + 1;
    end
  end

  assign bus.add_result = ad_res;
  assign bus.add_carry  = ad_c;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Starts at the negedge of an IDLE cycle (cycle 0) and ends at the negedge of cycle L+4.
  task automatic run_job(input logic [1:0] req, input logic [W-1:0] a0, b0, a1, b1,
                         input logic drop, input logic change,
                         input logic [1:0] eg, input logic [W:0] es);
    logic [W-1:0] ea, eb;
    ea = eg[1] ? a1 : a0;
    eb = eg[1] ? b1 : b0;
    req_i = req; a0_i = a0; b0_i = b0; a1_i = a1; b1_i = b1;
    for (int c = 1; c <= L + 4; c++) begin
      @(negedge clk);
      if (c == 1) begin
        check("grant", grant_o, eg);
        check("busy", busy_o, 1);
        check("clear", bus.add_reset, 1);
        if (change) begin
          a0_i = ~a0; b0_i = ~b0; a1_i = ~a1; b1_i = ~b1;
        end
      end else if (c == 2) begin
        check("load", bus.add_load, 1);
        check("add_a", bus.add_a, ea);
        check("add_b", bus.add_b, eb);
      end else if (c <= L + 2) begin
        check("early_done", done_o, 0);
      end else if (c == L + 3) begin
        check("done", done_o, eg);
        check("grant_hold", grant_o, eg);
        if (drop) req_i = 2'b00;
      end else begin
        check("sum", sum_o, es);
        check("idle", busy_o, 0);
        check("grant_idle", grant_o, 0);
      end
    end
    ptr = eg[1];
  endtask

  typedef struct {
    logic [1:0]   req;
    logic [W-1:0] a0, b0, a1, b1;
    logic         drop;
    logic [1:0]   eg;
    logic [W:0]   es;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]   rq, eg;
    logic [W-1:0] ra0, rb0, ra1, rb1;
    logic         w;

    vecs[0] = '{2'b01, 8'd7,   8'd3,   8'd0, 8'd0, 1'b1, 2'b01, 9'd10};
    vecs[1] = '{2'b10, 8'd0,   8'd0,   8'd6, 8'd4, 1'b1, 2'b10, 9'd10};
    vecs[2] = '{2'b11, 8'd1,   8'd2,   8'd5, 8'd5, 1'b0, 2'b01, 9'd3};
    vecs[3] = '{2'b11, 8'd1,   8'd2,   8'd5, 8'd5, 1'b0, 2'b10, 9'd10};
    vecs[4] = '{2'b11, 8'd1,   8'd2,   8'd5, 8'd5, 1'b0, 2'b01, 9'd3};
    vecs[5] = '{2'b11, 8'd1,   8'd2,   8'd5, 8'd5, 1'b1, 2'b10, 9'd10};
    vecs[6] = '{2'b01, 8'd255, 8'd255, 8'd0, 8'd0, 1'b1, 2'b01, 9'h1FE};

    reset = 1'b1; req_i = '0; a0_i = '0; b0_i = '0; a1_i = '0; b1_i = '0;
    ptr = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_grant", grant_o, 0);
    check("rst_done", done_o, 0);
    check("rst_sum", sum_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_add_reset", bus.add_reset, 1);
    check("rst_add_load", bus.add_load, 0);
    check("rst_add_a", bus.add_a, 0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_add_reset", bus.add_reset, 0);
    check("post_rst_busy", busy_o, 0);

    for (int i = 0; i < 7; i++)
      run_job(vecs[i].req, vecs[i].a0, vecs[i].b0, vecs[i].a1, vecs[i].b1,
              vecs[i].drop, 1'b0, vecs[i].eg, vecs[i].es);

    // Operands changed right after grant must not affect the job.
    run_job(2'b01, 8'd20, 8'd30, 8'd0, 8'd0, 1'b1, 1'b1, 2'b01, 9'd50);

    // Reset during RUN: no done, pointer back to 1 so requester 0 wins the next tie.
    req_i = 2'b11; a0_i = 8'd40; b0_i = 8'd2; a1_i = 8'd100; b1_i = 8'd100;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      check("mid_done", done_o, 0);
    end
    check("mid_busy", busy_o, 1);
    reset = 1'b1;
    #1;
    check("mid_add_reset", bus.add_reset, 1);
    @(negedge clk);
    check("abort_busy", busy_o, 0);
    check("abort_done", done_o, 0);
    check("abort_sum", sum_o, 0);
    check("abort_grant", grant_o, 0);
    reset = 1'b0;
    ptr = 1'b1;
    run_job(2'b11, 8'd40, 8'd2, 8'd100, 8'd100, 1'b1, 1'b0, 2'b01, 9'd42);

    for (int i = 0; i < 24; i++) begin
      rq  = 2'($urandom_range(1, 3));
      ra0 = W'($urandom); rb0 = W'($urandom);
      ra1 = W'($urandom); rb1 = W'($urandom);
      if (rq == 2'b01)      w = 1'b0;
      else if (rq == 2'b10) w = 1'b1;
      else                  w = ~ptr;
      eg = w ? 2'b10 : 2'b01;
      run_job(rq, ra0, rb0, ra1, rb1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), eg,
              w ? ({1'b0, ra1} + {1'b0, rb1}) : ({1'b0, ra0} + {1'b0, rb0}));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
